// File: rtl/mem_ctrl.sv
// Purpose: serves the CPU's 32-bit rom and ram ports from one byte-wide synchronous memory, four byte cycles per word.
// Latency: 7 cycles per read, 6 per write (stall high until the DONE cycle); ram+rom together take 13 (ram read) or 12 (ram write).
// Backpressure: stallreq_o holds the pipeline while any request is pending; both ports are released together in the DONE cycle.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              ram_ce_i,
    input  logic              ram_we_i,
    input  logic [3:0]        ram_sel_i,
    input  logic [31:0]       ram_addr_i,
    input  logic [31:0]       ram_data_i,
    output logic [31:0]       ram_data_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    input  logic [7:0]        mem_din_i,
    output logic              mem_wr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        k;
    logic              cur;        // 1 = ram transfer, 0 = rom transfer
    logic              ram_done;
    logic              rom_done;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [3:0]        sel;
    logic              we;
    logic [23:0]       acc;        // bytes 0..2 of the word being read

    logic ram_pend, rom_pend;
    assign ram_pend = ram_ce_i & ~ram_done;
    assign rom_pend = rom_ce_i & ~rom_done;

    // Upper CPU address bits are dropped: the external memory is only ADDR_W bits wide.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W], rom_addr_i[31:ADDR_W]};

    // Request latching, byte counter, read assembly and completion bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= 2'd0;
            cur        <= 1'b0;
            ram_done   <= 1'b0;
            rom_done   <= 1'b0;
            base       <= '0;
            wdata      <= 32'd0;
            sel        <= 4'd0;
            we         <= 1'b0;
            acc        <= 24'd0;
            rom_data_o <= 32'd0;
            ram_data_o <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (ram_pend) begin
                        base  <= ram_addr_i[ADDR_W-1:0];
                        wdata <= ram_data_i;
                        sel   <= ram_sel_i;
                        we    <= ram_we_i;
                        cur   <= 1'b1;
                        k     <= 2'd0;
                    end else if (rom_pend) begin
                        base <= rom_addr_i[ADDR_W-1:0];
                        we   <= 1'b0;
                        cur  <= 1'b0;
                        k    <= 2'd0;
                    end
                end
                XFER: begin
                    // Read data lags its address by one cycle, so byte k-1 arrives now.
                    if (!we) begin
                        case (k)
                            2'd1:    acc[7:0]   <= mem_din_i;
                            2'd2:    acc[15:8]  <= mem_din_i;
                            2'd3:    acc[23:16] <= mem_din_i;
                            default: ;
                        endcase
                    end
                    k <= k + 2'd1;
                    if (we && k == 2'd3) begin
                        ram_done <= 1'b1;
                    end
                end
                TAIL: begin
                    if (cur) begin
                        ram_data_o <= {mem_din_i, acc};
                        ram_done   <= 1'b1;
                    end else begin
                        rom_data_o <= {mem_din_i, acc};
                        rom_done   <= 1'b1;
                    end
                end
                DONE: begin
                    ram_done <= 1'b0;
                    rom_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next state plus the combinational external-memory drive (idle outputs stay at zero).
    always_comb begin
        state_nx   = state;
        mem_a_o    = '0;
        mem_dout_o = 8'd0;
        mem_wr_o   = 1'b0;
        case (state)
            IDLE: begin
                if (ram_pend || rom_pend) begin
                    state_nx = XFER;
                end else if (ram_done || rom_done) begin
                    state_nx = DONE;
                end
            end
            XFER: begin
                mem_a_o = base + ADDR_W'(k);
                if (we) begin
                    mem_dout_o = wdata[{k, 3'b000} +: 8];
                    mem_wr_o   = sel[k];
                end
                if (k == 2'd3) begin
                    state_nx = we ? IDLE : TAIL;
                end
            end
            TAIL:    state_nx = IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign stallreq_o = (rom_ce_i | ram_ce_i) & (state != DONE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Purpose: scoreboard bench for mem_ctrl with a byte-wide synchronous memory model.
// Latency: expected byte accesses and per-request stall lengths/results are queued at issue time.
// Backpressure: driver waits (bounded) for stallreq_o to drop before issuing the next request.
module tb_mem_ctrl;

    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic              rom_ce_i;
    logic [31:0]       rom_addr_i;
    logic [31:0]       rom_data_o;
    logic              ram_ce_i;
    logic              ram_we_i;
    logic [3:0]        ram_sel_i;
    logic [31:0]       ram_addr_i;
    logic [31:0]       ram_data_i;
    logic [31:0]       ram_data_o;
    logic              stallreq_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic [7:0]        mem_dout_o;
    logic [7:0]        mem_din_i;
    logic              mem_wr_o;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .ram_ce_i   (ram_ce_i),
        .ram_we_i   (ram_we_i),
        .ram_sel_i  (ram_sel_i),
        .ram_addr_i (ram_addr_i),
        .ram_data_i (ram_data_i),
        .ram_data_o (ram_data_o),
        .stallreq_o (stallreq_o),
        .mem_a_o    (mem_a_o),
        .mem_dout_o (mem_dout_o),
        .mem_din_i  (mem_din_i),
        .mem_wr_o   (mem_wr_o)
    );

    always #5 clk = ~clk;

    // Byte-wide synchronous memory: read data appears the cycle after its address.
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_a  = '0;
    logic [7:0]        load_d  = 8'd0;
    always @(posedge clk) begin
        if (load_en) mem[load_a] <= load_d;
        else if (mem_wr_o) mem[mem_a_o] <= mem_dout_o;
        mem_din_i <= mem[mem_a_o];
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [7:0]        dout;
    } acc_t;

    typedef struct {
        int          stall;
        bit          chk_rom;
        logic [31:0] rom;
        bit          chk_ram;
        logic [31:0] ram;
    } txn_t;

    acc_t exp_acc[$];
    txn_t exp_txn[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   run   = 0;

    // Monitor: byte accesses during XFER, no stray writes elsewhere, and per-request results at release.
    always @(negedge clk) begin
        acc_t e;
        txn_t t;
        if (dut.state == 2'd1) begin
            n_cmp++;
            if (exp_acc.size() == 0) begin
                n_bad++;
                $display("FAIL xfer_unexpected: mem_a_o=%h mem_wr_o=%b, no access expected", mem_a_o, mem_wr_o);
            end else begin
                e = exp_acc.pop_front();
                if (mem_a_o !== e.addr || mem_wr_o !== e.wr || (e.wr && mem_dout_o !== e.dout)) begin
                    n_bad++;
                    $display("FAIL xfer_access: got a=%h wr=%b d=%h, want a=%h wr=%b d=%h",
                             mem_a_o, mem_wr_o, mem_dout_o, e.addr, e.wr, e.dout);
                end
            end
        end else begin
            n_cmp++;
            if (mem_wr_o !== 1'b0) begin
                n_bad++;
                $display("FAIL stray_write: mem_wr_o=%b a=%h outside a write transfer", mem_wr_o, mem_a_o);
            end
        end

        if (stallreq_o === 1'b1) begin
            run++;
        end else if (rom_ce_i || ram_ce_i) begin
            n_cmp++;
            if (exp_txn.size() == 0) begin
                n_bad++;
                $display("FAIL release_unexpected: stall window %0d with no request queued", run);
            end else begin
                t = exp_txn.pop_front();
                if (run != t.stall) begin
                    n_bad++;
                    $display("FAIL stall_len: got %0d cycles, want %0d", run, t.stall);
                end
                if (t.chk_rom && rom_data_o !== t.rom) begin
                    n_bad++;
                    $display("FAIL rom_data: got %h, want %h", rom_data_o, t.rom);
                end
                if (t.chk_ram && ram_data_o !== t.ram) begin
                    n_bad++;
                    $display("FAIL ram_data: got %h, want %h", ram_data_o, t.ram);
                end
            end
            run = 0;
        end else begin
            run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        load_a  = a;
        load_d  = d;
        load_en = 1'b1;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic push_acc(input logic [31:0] a, input logic wr, input logic [3:0] s, input logic [31:0] d);
        acc_t e;
        for (int i = 0; i < 4; i++) begin
            e.addr = a[ADDR_W-1:0] + ADDR_W'(i);
            e.wr   = wr & s[i];
            e.dout = d[8*i +: 8];
            exp_acc.push_back(e);
        end
    endtask

    task automatic push_txn(input int st, input bit cr, input logic [31:0] r, input bit cm, input logic [31:0] m);
        txn_t t;
        t.stall   = st;
        t.chk_rom = cr;
        t.rom     = r;
        t.chk_ram = cm;
        t.ram     = m;
        exp_txn.push_back(t);
    endtask

    // Wait (bounded) for the release cycle, then advance past its edge like the pipeline would.
    task automatic wait_release(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stallreq_o === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: stallreq_o=%b, want release within 40 cycles", name, stallreq_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic rce, input logic [31:0] raddr,
                         input logic dce, input logic dwe, input logic [3:0] dsel,
                         input logic [31:0] daddr, input logic [31:0] ddata);
        rom_ce_i   = rce;
        rom_addr_i = raddr;
        ram_ce_i   = dce;
        ram_we_i   = dwe;
        ram_sel_i  = dsel;
        ram_addr_i = daddr;
        ram_data_i = ddata;
        wait_release(name);
    endtask

    task automatic go_idle();
        rom_ce_i = 1'b0;
        ram_ce_i = 1'b0;
        ram_we_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pre_a [16];
        logic [7:0] pre_d [16];
        rst        = 1'b1;
        rom_ce_i   = 1'b0;
        rom_addr_i = 32'd0;
        ram_ce_i   = 1'b0;
        ram_we_i   = 1'b0;
        ram_sel_i  = 4'd0;
        ram_addr_i = 32'd0;
        ram_data_i = 32'd0;

        // Preload while reset is held.
        load(17'h00040, 8'h13); load(17'h00041, 8'h00); load(17'h00042, 8'h50); load(17'h00043, 8'h00);
        load(17'h00044, 8'h93); load(17'h00045, 8'h08); load(17'h00046, 8'h10); load(17'h00047, 8'h00);
        load(17'h00100, 8'h11); load(17'h00101, 8'h22); load(17'h00102, 8'h33); load(17'h00103, 8'h44);
        load(17'h1FFFE, 8'hA1); load(17'h1FFFF, 8'hB2); load(17'h00000, 8'hC3); load(17'h00001, 8'hD4);
        load(17'h00300, 8'h00); load(17'h00301, 8'h00); load(17'h00302, 8'h00); load(17'h00303, 8'h00);
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_rom_data", rom_data_o, 32'd0);
        check("rst_ram_data", ram_data_o, 32'd0);
        check("rst_mem_a", 32'(mem_a_o), 32'd0);
        check("rst_stall_noreq", 32'(stallreq_o), 32'd0);
        @(posedge clk);
        #1;

        // Rom-only fetch.
        push_acc(32'h40, 1'b0, 4'h0, 32'h0);
        push_txn(7, 1'b1, 32'h00500013, 1'b0, 32'h0);
        issue("rom_fetch", 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        go_idle();

        // Partial write: lanes 0 and 2 only; ram_data_o must stay at its reset value.
        push_acc(32'h100, 1'b1, 4'b0101, 32'hAABBCCDD);
        push_txn(6, 1'b0, 32'h0, 1'b1, 32'h0);
        issue("part_write", 1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h100, 32'hAABBCCDD);
        go_idle();

        // Read back: untouched lanes keep 0x22 and 0x44; sel is ignored on reads.
        push_acc(32'h100, 1'b0, 4'h0, 32'h0);
        push_txn(7, 1'b0, 32'h0, 1'b1, 32'h44BB22DD);
        issue("readback", 1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0);
        go_idle();

        // Ram write plus rom fetch: write first, 12 cycles, ram_data_o untouched.
        push_acc(32'h200, 1'b1, 4'hF, 32'h12345678);
        push_acc(32'h44, 1'b0, 4'h0, 32'h0);
        push_txn(12, 1'b1, 32'h00100893, 1'b1, 32'h44BB22DD);
        issue("write_rom", 1'b1, 32'h44, 1'b1, 1'b1, 4'hF, 32'h200, 32'h12345678);
        go_idle();

        // Ram read plus rom fetch: ram bytes first, 13 cycles, both words correct.
        push_acc(32'h200, 1'b0, 4'h0, 32'h0);
        push_acc(32'h40, 1'b0, 4'h0, 32'h0);
        push_txn(13, 1'b1, 32'h00500013, 1'b1, 32'h12345678);
        issue("read_rom", 1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        go_idle();

        // Wrap-around fetch with upper address bits set (truncated away).
        push_acc(32'h0001FFFE, 1'b0, 4'h0, 32'h0);
        push_txn(7, 1'b1, 32'hD4C3B2A1, 1'b0, 32'h0);
        issue("wrap", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        go_idle();

        // Back-to-back fetches: next request presented right after the release edge.
        push_acc(32'h40, 1'b0, 4'h0, 32'h0);
        push_txn(7, 1'b1, 32'h00500013, 1'b0, 32'h0);
        push_acc(32'h44, 1'b0, 4'h0, 32'h0);
        push_txn(7, 1'b1, 32'h00100893, 1'b0, 32'h0);
        issue("b2b_first", 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        issue("b2b_second", 1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        go_idle();

        // Reset during the k=1 write cycle: only bytes 0 and 1 reach memory.
        begin
            acc_t e;
            e.addr = 17'h00300; e.wr = 1'b1; e.dout = 8'hBE; exp_acc.push_back(e);
            e.addr = 17'h00301; e.wr = 1'b1; e.dout = 8'hBA; exp_acc.push_back(e);
        end
        ram_ce_i   = 1'b1;
        ram_we_i   = 1'b1;
        ram_sel_i  = 4'hF;
        ram_addr_i = 32'h300;
        ram_data_i = 32'hCAFEBABE;
        @(posedge clk);   // into XFER k=0
        @(posedge clk);   // into XFER k=1
        #1;
        rst      = 1'b1;
        ram_ce_i = 1'b0;
        ram_we_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_state", 32'(dut.state), 32'd0);
        check("mid_rst_rom_data", rom_data_o, 32'd0);
        check("mid_rst_ram_data", ram_data_o, 32'd0);
        check("mid_rst_mem_a", 32'(mem_a_o), 32'd0);
        check("mid_rst_mem_dout", 32'(mem_dout_o), 32'd0);
        check("mid_rst_mem_wr", 32'(mem_wr_o), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_rst_byte0", 32'(mem[17'h00300]), 32'h000000BE);
        check("mid_rst_byte1", 32'(mem[17'h00301]), 32'h000000BA);
        check("mid_rst_byte2", 32'(mem[17'h00302]), 32'h00000000);
        check("mid_rst_byte3", 32'(mem[17'h00303]), 32'h00000000);

        // All queued expectations consumed.
        check("acc_queue_left", 32'(exp_acc.size()), 32'd0);
        check("txn_queue_left", 32'(exp_txn.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory responder on the far side of the CPU core's instruction (rom) and data (ram) ports. It serves both 32-bit ports from one single-ported, byte-wide synchronous memory, performing four byte transfers per word. It raises `stallreq_o` toward the pipeline control unit until each request is complete. Data-port requests have priority over instruction fetches; when both are pending, they are served back-to-back and released together.

## Interface

Parameters:
- `ADDR_W`, 17: byte address width of the external memory; CPU addresses are truncated to `ADDR_W` bits.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rom_ce_i`  in  1  instruction fetch request
- `rom_addr_i`  in  32  fetch byte address
- `rom_data_o`  out  32  fetched word, registered
- `ram_ce_i`  in  1  data access request
- `ram_we_i`  in  1  1 = write, 0 = read
- `ram_sel_i`  in  4  byte-lane enables for writes; bit k selects byte k
- `ram_addr_i`  in  32  data byte address
- `ram_data_i`  in  32  write data from the CPU
- `ram_data_o`  out  32  read word, registered
- `stallreq_o`  out  1  stall request to the control unit
- `mem_a_o`  out  ADDR_W  external byte address
- `mem_dout_o`  out  8  external write byte
- `mem_din_i`  in  8  external read byte, valid the cycle after its address
- `mem_wr_o`  out  1  external write strobe

## Operation

- Byte order is little-endian: the byte at `base+k` maps to bits `[8k+7:8k]`, for k = 0..3.
- The base address is the low `ADDR_W` bits of the request address. `base+k` wraps modulo 2^`ADDR_W`. Unaligned bases are legal.
- State machine: IDLE, XFER, TAIL, DONE. A 2-bit counter `k` tracks the byte index, and a `cur` flag records whether the current transfer is ram or rom. Two pending flags (`ram_done`, `rom_done`) record which requests have been served.
- IDLE:
  - If `ram_ce_i` is high and not yet served, latch the ram address, write data, sel and we. Set `cur`=ram, `k`=0, and go to XFER.
  - Otherwise, if `rom_ce_i` is high and not yet served, latch the rom address, set `cur`=rom, `k`=0, and go to XFER.
  - If neither applies and at least one port has been served, go to DONE.
  - Otherwise stay in IDLE.
- XFER:
  - Drive `mem_a_o` = base+`k`.
  - For a write, drive `mem_dout_o` = byte `k` of the write data and `mem_wr_o` = `sel[k]`. A disabled lane still spends its cycle.
  - For a read, capture `mem_din_i` into byte `k-1` of the result when `k`>0.
  - Increment `k`. After `k`=3, a read goes to TAIL; a write marks `ram_done` and returns to IDLE.
- TAIL: capture `mem_din_i` into byte 3. Write the assembled word to `ram_data_o` or `rom_data_o` according to `cur`, mark that port done, and return to IDLE.
- DONE: lasts one cycle. Clear both done flags and go to IDLE. The pipeline advances at this edge.
- `stallreq_o` is combinational: `(rom_ce_i | ram_ce_i) & (state != DONE)`.
- `mem_wr_o` is 0 in every state other than XFER with a write.
- Data reads fetch all four bytes regardless of `ram_sel_i`; the CPU's mem stage extracts lanes.
- A write leaves `ram_data_o` unchanged.
- The CPU holds every request input stable while `stallreq_o` is high. This block does not re-check inputs mid-transfer and uses only the latched copies.

## Timing

- Reset values: `rom_data_o`=0, `ram_data_o`=0, `mem_a_o`=0, `mem_dout_o`=0, `mem_wr_o`=0, state=IDLE, `k`=0, both done flags=0. `stallreq_o` still follows its equation after reset, so it is high if a request is present.
- A reset asserted mid-transfer aborts the access at the next edge. Bytes already written remain in memory. No further `mem_wr_o` pulses follow.
- Rom read only: 1 IDLE + 4 XFER + 1 TAIL + 1 IDLE + 1 DONE cycles.
  - `stallreq_o` is high for 7 cycles and low in the DONE cycle.
  - `rom_data_o` is valid from the cycle after TAIL onward.
- Ram write only: 1 IDLE + 4 XFER + 1 IDLE + 1 DONE. `stallreq_o` is high for 6 cycles.
- Ram and rom together: the ram transfer completes in full, then the rom transfer, then a single DONE. Both ports release in the same cycle.
- Back-to-back requests: the next request is first seen in the IDLE cycle after DONE, so there are no lost or duplicated accesses.
- Throughput: one word per 7 cycles (read) or 6 cycles (write). A combined ram+rom access takes 13 cycles when ram is a read and 12 when it is a write.

## Test plan

- Rom-only fetch: preload bytes 0x40..0x43 = 13,00,50,00, then assert `rom_ce_i` at `rom_addr_i`=0x40.
  - `mem_a_o` steps 0x40..0x43 on consecutive cycles.
  - `stallreq_o` is high for exactly 7 cycles.
  - `rom_data_o`=0x00500013.
- Partial write: `ram_we_i`=1, `ram_sel_i`=4'b0101, address 0x100, data 0xAABBCCDD.
  - `mem_wr_o` pulses only with `mem_a_o`=0x100 (0xDD) and 0x102 (0xBB).
  - A subsequent read of 0x100 returns 0x??BB??DD, with untouched bytes preserved.
- Simultaneous rom fetch at 0x40 and ram read at 0x100: the ram bytes are accessed first, then the rom bytes. `stallreq_o` is high for 13 cycles, then low for 1 cycle, with both outputs correct.
- Wrap-around: read at address 2^`ADDR_W`−2. `mem_a_o` sequence is 0x1FFFE, 0x1FFFF, 0x00000, 0x00001, and the assembled word is correct.
- Reset mid-write: assert `rst` during the XFER cycle of a write with `k`=1.
  - Bytes 2 and 3 are never written.
  - The cycle after reset, all outputs equal their reset values and the state is IDLE.
- Back-to-back fetches at 0x40 then 0x44: two distinct 7-cycle stall windows separated by one low cycle. No access is repeated.
